// File: rtl/matrix_op_if.sv
// rtl/matrix_op_if.sv - memory handshake, run control and status bundle for matrix_op_engine
interface matrix_op_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              enable;
    logic              mem_opdone;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic [ADDR_W-1:0] addr_o;
    logic [1:0]        mem_operation;
    logic              done;
    logic              error;

    modport master (
        input  enable, mem_opdone, data_i,
        output data_o, addr_o, mem_operation, done, error
    );

    modport slave (
        output enable, mem_opdone, data_i,
        input  data_o, addr_o, mem_operation, done, error
    );
endinterface

// File: rtl/matrix_op_engine.sv
// rtl/matrix_op_engine.sv - memory-mapped matrix coprocessor (MUL, ADD, TRANSPOSE, HADAMARD)
module matrix_op_engine #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int          ACC_W     = 64,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic       clk,
    input  logic       reset,
    matrix_op_if.master bus
);
    typedef enum logic [3:0] {IDLE, FETCH, CHECK, ERR, LOOP, RD_A, RD_B, MAC, WR, DONE} state_t;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b11;
    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_ADD   = 2'd1;
    localparam logic [1:0] OP_TRN   = 2'd2;
    localparam logic [1:0] OP_HAD   = 2'd3;

    localparam logic [ADDR_W-1:0] PARAM_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] A_BASE     = PARAM_BASE + ADDR_W'(6);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    state;
    logic [2:0]                fidx;
    logic [DATA_W-1:0]         opc, wa, ha, wb, hb, c_rows, c_cols, i, j, k;
    logic [ADDR_W-1:0]         b_base, c_base;
    logic signed [DATA_W-1:0]  a_val, b_val;
    logic signed [ACC_W-1:0]   acc;

    logic [ADDR_W-1:0]         i_x, j_x, k_x, wa_x, ha_x, wb_x, hb_x, cc_x;
    logic [ADDR_W-1:0]         a_addr, b_addr, c_addr;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_x, sum_x;
    logic [DATA_W-1:0]         sat_val, rows_n, cols_n;
    logic                      dim_err, last_i, last_j, last_k;

    assign i_x  = ADDR_W'(i);
    assign j_x  = ADDR_W'(j);
    assign k_x  = ADDR_W'(k);
    assign wa_x = ADDR_W'(wa);
    assign ha_x = ADDR_W'(ha);
    assign wb_x = ADDR_W'(wb);
    assign hb_x = ADDR_W'(hb);
    assign cc_x = ADDR_W'(c_cols);

    // (i, j) always indexes the C element being produced; transpose reads A[j][i]
    always_comb begin
        a_addr = A_BASE + i_x * wa_x + j_x;
        b_addr = b_base + i_x * wb_x + j_x;
        case (opc[1:0])
            OP_MUL: begin
                a_addr = A_BASE + i_x * wa_x + k_x;
                b_addr = b_base + k_x * wb_x + j_x;
            end
            OP_TRN: a_addr = A_BASE + j_x * wa_x + i_x;
            default: ;
        endcase
    end
    assign c_addr = c_base + i_x * cc_x + j_x;

    assign prod   = (2*DATA_W)'(a_val) * (2*DATA_W)'(b_val);
    assign prod_x = ACC_W'(prod);
    assign sum_x  = ACC_W'(a_val) + ACC_W'(b_val);

    always_comb begin
        if (acc > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
        else if (acc < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
        else                    sat_val = acc[DATA_W-1:0];
    end

    always_comb begin
        rows_n = ha;
        cols_n = wa;
        case (opc[1:0])
            OP_MUL: cols_n = wb;
            OP_TRN: begin rows_n = wa; cols_n = ha; end
            default: ;
        endcase
    end

    assign dim_err = (opc > DATA_W'(3))
                   || (opc[1:0] == OP_MUL && wa != hb)
                   || ((opc[1:0] == OP_ADD || opc[1:0] == OP_HAD) && (ha != hb || wa != wb));
    assign last_k = (k == wa - DATA_W'(1));
    assign last_j = (j == c_cols - DATA_W'(1));
    assign last_i = (i == c_rows - DATA_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            fidx              <= '0;
            {opc, wa, ha, wb, hb} <= '0;
            {c_rows, c_cols}  <= '0;
            {i, j, k}         <= '0;
            b_base            <= '0;
            c_base            <= '0;
            a_val             <= '0;
            b_val             <= '0;
            acc               <= '0;
            bus.mem_operation <= MEM_NONE;
            bus.addr_o        <= '0;
            bus.data_o        <= '0;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
        end else if (bus.enable || state == DONE || state == ERR) begin
            case (state)
                IDLE: begin
                    fidx  <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    if (bus.mem_operation == MEM_NONE) begin
                        bus.mem_operation <= MEM_RD;
                        bus.addr_o        <= PARAM_BASE + ADDR_W'(fidx);
                    end else if (bus.mem_opdone) begin
                        bus.mem_operation <= MEM_NONE;
                        case (fidx)
                            3'd0:    opc <= bus.data_i;
                            3'd1:    wa  <= bus.data_i;
                            3'd2:    ha  <= bus.data_i;
                            3'd3:    wb  <= bus.data_i;
                            default: hb  <= bus.data_i;
                        endcase
                        fidx <= fidx + 3'd1;
                        if (fidx == 3'd4) state <= CHECK;
                    end
                end
                CHECK: begin
                    c_rows <= rows_n;
                    c_cols <= cols_n;
                    b_base <= A_BASE + ha_x * wa_x;
                    c_base <= A_BASE + ha_x * wa_x + hb_x * wb_x;
                    i      <= '0;
                    j      <= '0;
                    if (dim_err) begin
                        bus.error <= 1'b1;
                        bus.done  <= 1'b1;
                        state     <= ERR;
                    end else if (rows_n == '0 || cols_n == '0) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= LOOP;
                    end
                end
                LOOP: begin
                    k   <= '0;
                    acc <= '0;
                    // an empty inner product still writes its (zero) element
                    state <= (opc[1:0] == OP_MUL && wa == '0) ? WR : RD_A;
                end
                RD_A: begin
                    if (bus.mem_operation == MEM_NONE) begin
                        bus.mem_operation <= MEM_RD;
                        bus.addr_o        <= a_addr;
                    end else if (bus.mem_opdone) begin
                        bus.mem_operation <= MEM_NONE;
                        a_val             <= $signed(bus.data_i);
                        if (opc[1:0] == OP_TRN) begin
                            acc   <= ACC_W'($signed(bus.data_i));
                            state <= WR;
                        end else begin
                            state <= RD_B;
                        end
                    end
                end
                RD_B: begin
                    if (bus.mem_operation == MEM_NONE) begin
                        bus.mem_operation <= MEM_RD;
                        bus.addr_o        <= b_addr;
                    end else if (bus.mem_opdone) begin
                        bus.mem_operation <= MEM_NONE;
                        b_val             <= $signed(bus.data_i);
                        state             <= MAC;
                    end
                end
                MAC: begin
                    case (opc[1:0])
                        OP_MUL:  acc <= acc + prod_x;
                        OP_ADD:  acc <= sum_x;
                        default: acc <= prod_x;
                    endcase
                    if (opc[1:0] == OP_MUL && !last_k) begin
                        k     <= k + DATA_W'(1);
                        state <= RD_A;
                    end else begin
                        state <= WR;
                    end
                end
                WR: begin
                    if (bus.mem_operation == MEM_NONE) begin
                        bus.mem_operation <= MEM_WR;
                        bus.addr_o        <= c_addr;
                        bus.data_o        <= sat_val;
                    end else if (bus.mem_opdone) begin
                        bus.mem_operation <= MEM_NONE;
                        if (!last_j) begin
                            j     <= j + DATA_W'(1);
                            state <= LOOP;
                        end else if (!last_i) begin
                            j     <= '0;
                            i     <= i + DATA_W'(1);
                            state <= LOOP;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE, ERR: begin
                    if (!bus.enable) begin
                        bus.done  <= 1'b0;
                        bus.error <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_op_engine.sv
// tb/tb_matrix_op_engine.sv - randomized self-checking bench for matrix_op_engine
module tb_matrix_op_engine;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int ACCW = 40;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matrix_op_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    matrix_op_engine #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACCW), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic signed [DW-1:0] mem [0:255];
    wr_t   exp_q[$];
    bit    exp_err;
    int    exp_reads;
    int    n_reads, n_writes;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    max_delay = 0;

    bit          pending = 1'b0;
    int          wait_cnt;
    logic [1:0]  prev_op = 2'b00;
    logic [1:0]  lat_op;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    wr_t         got;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic longint rd(input int a);
        return longint'(mem[8'(a)]);
    endfunction

    task automatic poke(input int a, input int v);
        mem[8'(a)] = DW'(v);
    endtask

    function automatic int sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Reference model: expected write list, read count and error from the parameter block in mem
    task automatic build_model();
        int op, wa, ha, wb, hb, bb, cb, cr, cc;
        longint acc;
        op = int'(rd(0)); wa = int'(rd(1)); ha = int'(rd(2)); wb = int'(rd(3)); hb = int'(rd(4));
        exp_q.delete();
        exp_err   = 1'b0;
        exp_reads = 5;
        if (op < 0 || op > 3 || (op == 0 && wa != hb) ||
            ((op == 1 || op == 3) && (ha != hb || wa != wb))) begin
            exp_err = 1'b1;
            return;
        end
        bb = 6 + ha * wa;
        cb = bb + hb * wb;
        cr = (op == 2) ? wa : ha;
        cc = (op == 0) ? wb : (op == 2) ? ha : wa;
        for (int r = 0; r < cr; r++) begin
            for (int c = 0; c < cc; c++) begin
                case (op)
                    0: begin
                        acc = 0;
                        for (int kk = 0; kk < wa; kk++) begin
                            acc += rd(6 + r * wa + kk) * rd(bb + kk * wb + c);
                            exp_reads += 2;
                        end
                    end
                    1: begin acc = rd(6 + r * wa + c) + rd(bb + r * wb + c); exp_reads += 2; end
                    2: begin acc = rd(6 + c * wa + r); exp_reads += 1; end
                    default: begin acc = rd(6 + r * wa + c) * rd(bb + r * wb + c); exp_reads += 2; end
                endcase
                exp_q.push_back('{cb + r * cc + c, sat(acc)});
            end
        end
    endtask

    // Memory responder and per-cycle checker of the handshake and of every C write
    always @(negedge clk) begin
        if (bus.mem_operation == 2'b00) begin
            pending        = 1'b0;
            bus.mem_opdone = 1'b0;
        end else if (!pending) begin
            check("gap_before_request", longint'(prev_op), 0);
            pending        = 1'b1;
            wait_cnt       = int'($urandom_range(max_delay, 0));
            lat_op         = bus.mem_operation;
            lat_addr       = bus.addr_o;
            lat_data       = bus.data_o;
            bus.mem_opdone = 1'b0;
        end else begin
            check("hold_op", longint'(bus.mem_operation), longint'(lat_op));
            check("hold_addr", longint'(bus.addr_o), longint'(lat_addr));
            if (lat_op == 2'b11) check("hold_data", longint'(bus.data_o), longint'(lat_data));
            if (!bus.mem_opdone) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    bus.mem_opdone = 1'b1;
                    if (bus.mem_operation == 2'b01) begin
                        bus.data_i = mem[bus.addr_o[7:0]];
                        n_reads++;
                    end else begin
                        n_writes++;
                        mem[bus.addr_o[7:0]] = bus.data_o;
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_write: addr %0d data %0d, no write expected",
                                     bus.addr_o, $signed(bus.data_o));
                        end else begin
                            got = exp_q.pop_front();
                            check("write_addr", longint'(bus.addr_o), longint'(got.addr));
                            check("write_data", longint'($signed(bus.data_o)), longint'(got.data));
                        end
                    end
                end
            end
        end
        prev_op = bus.mem_operation;
    end

    task automatic setup(input int op, input int wa, input int ha, input int wb, input int hb);
        poke(0, op); poke(1, wa); poke(2, ha); poke(3, wb); poke(4, hb); poke(5, 0);
        for (int a = 6; a < 64; a++) mem[8'(a)] = DW'($urandom);
    endtask

    task automatic go(input int delay, input bit pulse);
        int cyc;
        cyc = 0;
        build_model();
        max_delay = delay;
        n_reads   = 0;
        n_writes  = 0;
        @(negedge clk);
        bus.enable = 1'b1;
        while (!bus.done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (pulse && !bus.done && bus.mem_operation == 2'b01 && $urandom_range(3, 0) == 0) begin
                bus.enable = 1'b0;
                repeat ($urandom_range(3, 1)) @(negedge clk);
                bus.enable = 1'b1;
            end
        end
        check("done_reached", longint'(bus.done), 1);
        check("error_flag", longint'(bus.error), longint'(exp_err));
        check("writes_remaining", longint'(exp_q.size()), 0);
        check("read_count", longint'(n_reads), longint'(exp_reads));
        repeat (2) @(negedge clk);
        check("done_held", longint'(bus.done), 1);
        bus.enable = 1'b0;
        @(negedge clk);
        check("done_cleared", longint'(bus.done), 0);
        check("error_cleared", longint'(bus.error), 0);
    endtask

    task automatic load_mul2x2();
        setup(0, 2, 2, 2, 2);
        poke(6, 1); poke(7, 2); poke(8, 3); poke(9, 4);
        poke(10, 5); poke(11, 6); poke(12, 7); poke(13, 8);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int op, wa, ha, wb, hb, cyc;
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_op", longint'(bus.mem_operation), 0);
        check("reset_addr", longint'(bus.addr_o), 0);
        check("reset_data", longint'(bus.data_o), 0);
        check("reset_done", longint'(bus.done), 0);
        check("reset_error", longint'(bus.error), 0);
        reset = 1'b0;

        // MUL 2x2
        load_mul2x2();
        build_model();
        check("model_mul_c00", longint'(exp_q[0].data), 19);
        check("model_mul_c01", longint'(exp_q[1].data), 22);
        check("model_mul_c10", longint'(exp_q[2].data), 43);
        check("model_mul_c11", longint'(exp_q[3].data), 50);
        check("model_mul_addr", longint'(exp_q[0].addr), 14);
        go(0, 1'b0);

        // TRANSPOSE 2x3, B empty
        setup(2, 3, 2, 0, 0);
        for (int a = 0; a < 6; a++) poke(6 + a, a + 1);
        build_model();
        check("model_trn_c1", longint'(exp_q[1].data), 4);
        check("model_trn_c2", longint'(exp_q[2].data), 2);
        check("model_trn_last_addr", longint'(exp_q[5].addr), 17);
        check("model_trn_reads", longint'(exp_reads), 11);
        go(0, 1'b0);

        // HADAMARD 1x1 saturation both ways
        setup(3, 1, 1, 1, 1);
        poke(6, 200); poke(7, -200);
        build_model();
        check("model_sat_neg", longint'(exp_q[0].data), -32768);
        go(0, 1'b0);
        setup(3, 1, 1, 1, 1);
        poke(6, 200); poke(7, 200);
        build_model();
        check("model_sat_pos", longint'(exp_q[0].data), 32767);
        go(1, 1'b0);

        // dimension error and bad op code
        setup(0, 3, 2, 2, 2);
        go(0, 1'b0);
        check("err_no_writes", longint'(n_writes), 0);
        setup(5, 1, 1, 1, 1);
        go(2, 1'b0);
        check("badop_no_writes", longint'(n_writes), 0);

        // zero sizes
        setup(0, 0, 2, 2, 0);
        build_model();
        check("model_mul_empty_k", longint'(exp_q[3].data), 0);
        go(0, 1'b0);
        setup(1, 2, 0, 2, 0);
        go(0, 1'b0);
        check("zero_c_no_writes", longint'(n_writes), 0);

        // ADD 2x2 with wait states and enable pulses during reads
        setup(1, 2, 2, 2, 2);
        go(5, 1'b1);

        // reset while the first C write is outstanding
        load_mul2x2();
        build_model();
        max_delay = 0;
        @(negedge clk);
        bus.enable = 1'b1;
        cyc = 0;
        while (bus.mem_operation != 2'b11 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_c_write", longint'(bus.mem_operation), 3);
        check("c_write_data", longint'($signed(bus.data_o)), 19);
        #2 reset = 1'b1;
        #1;
        check("async_reset_op", longint'(bus.mem_operation), 0);
        check("async_reset_addr", longint'(bus.addr_o), 0);
        check("async_reset_data", longint'(bus.data_o), 0);
        check("async_reset_done", longint'(bus.done), 0);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        load_mul2x2();
        go(0, 1'b0);

        // randomized operations
        for (int t = 0; t < 14; t++) begin
            op = int'($urandom_range(4, 0));
            wa = int'($urandom_range(3, 0));
            ha = int'($urandom_range(3, 0));
            wb = int'($urandom_range(3, 0));
            hb = int'($urandom_range(3, 0));
            if ($urandom_range(3, 0) != 0) begin
                if (op == 0) hb = wa;
                else begin hb = ha; wb = wa; end
            end
            setup(op, wa, ha, wb, hb);
            go(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
